// File: rtl/word_shift_pkg.sv
// Shared types and defaults for the word shift streamer.
// Optional checksum output is enabled with WORD_SHIFT_CHECKSUM_EN.
package word_shift_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int N_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0;

endpackage

// File: rtl/word_shift_buf.sv
// Parallel-load, shift-down word buffer; word 0 is the output word.
// Shared by all builds (see WORD_SHIFT_CHECKSUM_EN in the top).
module word_shift_buf
  import word_shift_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      shift,
  input  logic [N_WORDS*XLEN-1:0]   words_in,
  output logic [XLEN-1:0]           word0
);

  logic [N_WORDS-1:0][XLEN-1:0] sr_q;
  logic [N_WORDS-1:0][XLEN-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = words_in;
    end else if (shift) begin
      // zero word enters at the top as words drain out of slot 0
      sr_d = {XLEN'(ZERO_WORD), sr_q[N_WORDS-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign word0 = sr_q[0];

endmodule

// File: rtl/word_shift_streamer.sv
// Captures N_WORDS words and streams them with destination indices.
// Define WORD_SHIFT_CHECKSUM_EN to add the running checksum output.
module word_shift_streamer
  import word_shift_pkg::*;
#(
  parameter int N_WORDS   = N_WORDS_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_WORDS*XLEN-1:0] words_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [ADDR_W-1:0]       out_idx,
  output logic                    busy,
  output logic                    done
`ifdef WORD_SHIFT_CHECKSUM_EN
  ,
  output logic [XLEN-1:0]         checksum
`endif
);

  localparam int CNT_W = $clog2(N_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load;
  logic             shift;
  logic [XLEN-1:0]  word0;

  word_shift_buf #(
    .N_WORDS (N_WORDS),
    .XLEN    (XLEN)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .words_in (words_in),
    .word0    (word0)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (out_ready) begin
          shift = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == ST_SHIFT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_data  = out_valid ? word0 : '0;
  // index wraps modulo 2^ADDR_W by truncation
  assign out_idx   = out_valid
                   ? ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q)
                   : '0;

`ifdef WORD_SHIFT_CHECKSUM_EN
  logic [XLEN-1:0] csum_q;
  logic [XLEN-1:0] csum_d;

  always_comb begin
    csum_d = csum_q;
    if (load) begin
      csum_d = '0;
    end else if (shift) begin
      csum_d = csum_q + word0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_word_shift_streamer.sv
// Self-checking bench: queue-based model, directed cases, random streams.
// Covers WORD_SHIFT_CHECKSUM_EN when the macro is defined.
module tb_word_shift_streamer;

  localparam int NW = 8;
  localparam int XL = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic out_ready;
  logic [NW*XL-1:0] words_in;

  logic v1, b1, d1, v2, b2, d2;
  logic [XL-1:0] od1, od2;
  logic [AW-1:0] oi1, oi2;
`ifdef WORD_SHIFT_CHECKSUM_EN
  logic [XL-1:0] cs1, cs2;
`endif

  always #5 clk = ~clk;

  word_shift_streamer #(
    .N_WORDS(NW), .XLEN(XL), .ADDR_W(AW), .BASE_ADDR(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .words_in(words_in),
    .out_valid(v1), .out_ready(out_ready), .out_data(od1),
    .out_idx(oi1), .busy(b1), .done(d1)
`ifdef WORD_SHIFT_CHECKSUM_EN
    , .checksum(cs1)
`endif
  );

  word_shift_streamer #(
    .N_WORDS(NW), .XLEN(XL), .ADDR_W(AW), .BASE_ADDR(30)
  ) dut_w (
    .clk(clk), .rst(rst), .start(start), .words_in(words_in),
    .out_valid(v2), .out_ready(out_ready), .out_data(od2),
    .out_idx(oi2), .busy(b2), .done(d2)
`ifdef WORD_SHIFT_CHECKSUM_EN
    , .checksum(cs2)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  int c_words [8] = '{15, 7, 18, 55, 42, 17, 5, 81};
  int c_wrap  [8] = '{30, 31, 0, 1, 2, 3, 4, 5};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // behavioural model: queue of words still to be delivered
  logic [XL-1:0] m_q[$];
  int            m_k;
  bit            m_done;
  logic [XL-1:0] m_csum;
  bit            chk_en = 1'b0;
  int            hs_cnt = 0;

  logic [XL-1:0] obs_d[$];
  logic [AW-1:0] obs_i[$];
  logic [AW-1:0] obs_w[$];

  initial begin
    m_k    = 0;
    m_done = 1'b0;
    m_csum = '0;
  end

  always @(negedge clk) begin : cmp
    bit ev;
    if (chk_en) begin
      ev = (m_q.size() > 0);
      chk("valid", v1, ev);
      chk("valid_w", v2, ev);
      chk("busy", b1, ev || m_done);
      chk("busy_w", b2, ev || m_done);
      chk("done", d1, m_done);
      chk("done_w", d2, m_done);
      if (ev) begin
        chk("data", od1, m_q[0]);
        chk("data_w", od2, m_q[0]);
        chk("idx", oi1, (1 + m_k) % (1 << AW));
        chk("idx_w", oi2, (30 + m_k) % (1 << AW));
      end
`ifdef WORD_SHIFT_CHECKSUM_EN
      chk("csum", cs1, m_csum);
      chk("csum_w", cs2, m_csum);
`endif
      if (v1 && out_ready && !rst) begin
        obs_d.push_back(od1);
        obs_i.push_back(oi1);
        obs_w.push_back(oi2);
        hs_cnt++;
      end
      if (d1) begin
        chk("beats_per_stream", hs_cnt, NW);
        hs_cnt = 0;
      end
      if (rst) begin
        m_q.delete();
        m_k    = 0;
        m_done = 1'b0;
        m_csum = '0;
        hs_cnt = 0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_q.size() > 0) begin
        if (out_ready) begin
          m_csum = m_csum + m_q[0];
          void'(m_q.pop_front());
          m_k++;
          if (m_q.size() == 0) m_done = 1'b1;
        end
      end else if (start) begin
        m_k    = 0;
        m_csum = '0;
        for (int k = 0; k < NW; k++)
          m_q.push_back(words_in[k*XL +: XL]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_consts();
    for (int k = 0; k < NW; k++)
      words_in[k*XL +: XL] = XL'(c_words[k]);
  endtask

  task automatic load_random();
    for (int k = 0; k < NW; k++)
      words_in[k*XL +: XL] = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!d1 && n < 400) begin
      cyc();
      n++;
    end
    chk("done_timeout", d1, 1);
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_i.delete();
    obs_w.delete();
  endtask

  task automatic check_obs(input string tag);
    chk({tag, "_count"}, obs_d.size(), NW);
    for (int k = 0; k < NW && k < obs_d.size(); k++) begin
      chk({tag, "_lit_data"}, obs_d[k], c_words[k]);
      chk({tag, "_lit_idx"}, obs_i[k], k + 1);
      chk({tag, "_lit_wrap"}, obs_w[k], c_wrap[k]);
    end
  endtask

  initial begin
    int  n;
    bit  held;
    bit  st4;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    load_consts();
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_valid", v1, 0);
    chk("rst_busy", b1, 0);
    chk("rst_done", d1, 0);
    chk("rst_data", od1, 0);
    chk("rst_idx", oi1, 0);
`ifdef WORD_SHIFT_CHECKSUM_EN
    chk("rst_csum", cs1, 0);
`endif
    rst = 1'b0;
    cyc();

    // basic stream, words_in scrambled after capture
    clear_obs();
    start = 1'b1;
    cyc();
    start     = 1'b0;
    out_ready = 1'b1;
    load_random();
    chk("t1_first_data", od1, 15);
    chk("t1_first_idx", oi1, 1);
    chk("t1_first_wrap", oi2, 30);
    wait_done(n);
    chk("t1_latency", n, 8);
    check_obs("t1");
`ifdef WORD_SHIFT_CHECKSUM_EN
    chk("t1_csum_lit", cs1, 240);
`endif
    cyc();
    chk("t1_busy_fall", b1, 0);
    load_consts();

    // backpressure on beat 3 and ignored start pulses
    clear_obs();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n     = 0;
    held  = 1'b0;
    st4   = 1'b0;
    while (!d1 && n < 100) begin
      start = 1'b0;
      if (v1 && oi1 == 3 && !held) begin
        out_ready = 1'b0;
        repeat (3) begin
          cyc();
          chk("bp_data", od1, 18);
          chk("bp_idx", oi1, 3);
        end
        held      = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("bp_resume", od1, 55);
      end
      if (v1 && oi1 == 4 && !st4) begin
        start = 1'b1;
        st4   = 1'b1;
      end
      cyc();
      n++;
    end
    chk("t2_done_seen", d1, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_obs("t2");
    repeat (3) begin
      chk("t2_no_restart", v1, 0);
      chk("t2_idle", b1, 0);
      cyc();
    end

    // reset after beat 4 accepted
    clear_obs();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n     = 0;
    while (!(v1 && oi1 == 5) && n < 50) begin
      cyc();
      n++;
    end
    chk("t3_reach_beat5", oi1, 5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t3_rst_valid", v1, 0);
    chk("t3_rst_busy", b1, 0);
    clear_obs();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t3_restart_data", od1, 15);
    chk("t3_restart_idx", oi1, 1);
    chk("t3_restart_wrap", oi2, 30);
    wait_done(n);
    check_obs("t3");
    cyc();

    // random streams with random backpressure and stray starts
    for (int s = 0; s < 100; s++) begin
      load_random();
      repeat ($urandom_range(0, 3)) cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      n     = 0;
      while (!d1 && n < 400) begin
        out_ready = 1'($urandom_range(0, 1));
        start     = ($urandom_range(0, 7) == 0);
        load_random();
        cyc();
        n++;
      end
      chk("rnd_done_timeout", d1, 1);
      start = 1'($urandom_range(0, 1));
      cyc();
      start = 1'b0;
      chk("rnd_idle", v1, 0);
    end

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/word_shift_streamer.md
Name: word_shift_streamer

Overview:
- Sits directly downstream of the constant register-bank controller.
- Captures its eight 32-bit words in parallel on a start request, then streams them out one word per accepted beat over a valid/ready interface.
- Each beat carries a destination register index, so the consumer (register-file preload or write port) can write them sequentially.
- Pulses done after the last word is accepted.

Parameters:
- N_WORDS, 8, number of words captured and streamed.
- XLEN, 32, word width in bits.
- ADDR_W, 5, width of the destination index.
- BASE_ADDR, 1, destination index of the first streamed word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  capture request; honoured only in IDLE.
- words_in  input  N_WORDS*XLEN  parallel words; word k at bits [k*XLEN +: XLEN] (r0 at LSB).
- out_valid  output  1  out_data/out_idx hold a valid beat.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_data  output  XLEN  current word.
- out_idx  output  ADDR_W  destination index of the current word.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the final beat is accepted.
- checksum  output  XLEN  present only with the optional feature.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - State goes to IDLE.
  - out_valid, busy, done, out_data, out_idx, beat counter, buffer and checksum all go to 0.
  - Reset takes priority over every other event, including mid-stream; a partial stream is discarded and never resumed.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge T loads words_in into the shift buffer and clears the counter.
  - State goes to SHIFT, so out_valid=1 from cycle T+1 with out_data=word0 and out_idx=BASE_ADDR.
  - start=0: remain in IDLE.
- SHIFT:
  - out_data is always buffer word 0.
  - out_idx = (BASE_ADDR + cnt) mod 2^ADDR_W, so the index wraps silently.
  - On a handshake, the buffer shifts down one word (a zero word fills the top) and cnt increments.
  - Without a handshake (out_valid && !out_ready), out_data and out_idx hold stable; no beat is dropped or duplicated.
  - The handshake with cnt == N_WORDS-1 moves the state to DONE, and out_valid drops the next cycle.
- DONE: lasts exactly one cycle with done=1, out_valid=0 and busy=1, then returns to IDLE.
- Throughput: one word per cycle with out_ready held high. N_WORDS beats occupy cycles T+1..T+N_WORDS; done is asserted in cycle T+N_WORDS+1.
- start asserted in SHIFT or DONE is ignored, not queued. words_in changes after capture have no effect.
- out_ready while out_valid=0 has no effect.
- Counter width is clog2(N_WORDS)+1 bits.

Optional Feature:
- Macro: WORD_SHIFT_CHECKSUM_EN.
- Defined:
  - checksum port exists.
  - It is cleared on capture and incremented by out_data on every accepted beat, mod 2^XLEN.
  - Its value is final and stable from the DONE cycle until the next capture or reset.
- Undefined: the checksum port and its adder are absent; all other behaviour is identical.

Decomposition:
- Shared package word_shift_pkg holds:
  - XLEN and N_WORDS defaults.
  - The state enum (IDLE/SHIFT/DONE).
  - The 32-bit zero-word constant.
- One sub-module is natural: word_shift_buf, the N_WORDS x XLEN parallel-load, shift-down register with load/shift enables.
- The FSM, counter, index adder and checksum stay in the top module.

Test Plan:
- Capture of upstream constants 15,7,18,55,42,17,5,81 with out_ready=1:
  - 8 consecutive beats with data 15,7,18,55,42,17,5,81 and idx 1..8.
  - done pulses one cycle after beat 8; busy then falls.
  - checksum=240 when WORD_SHIFT_CHECKSUM_EN is defined.
- Backpressure: out_ready=0 for 3 cycles while beat 3 is presented -> out_data=18 and out_idx=3 held stable; the stream then resumes with 55.
- Ignored start: start pulsed during beat 4 and again in the DONE cycle -> the stream and counter are unaffected, and no second stream begins.
- Reset mid-stream: rst=1 after beat 4 is accepted -> out_valid=0 and busy=0 next cycle; a new start streams from 15 and idx 1 again.
- Index wrap: BASE_ADDR=30, ADDR_W=5 -> idx sequence 30,31,0,1,2,3,4,5.
- Random out_ready toggling over 100 streams -> the scoreboard sees each word exactly once, in order, with matching idx.
